// File: rtl/seg7_to_hex.sv
// Seven-segment pattern to hex nibble decoder with input stability filtering,
// a valid/ready output holding register, and illegal-pattern error reporting.
module seg7_to_hex #(
    parameter int unsigned Common_Anode_Cathode = 0,
    parameter int unsigned STABLE_CYCLES        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    output logic [3:0] hex_out,
    output logic       hex_valid,
    input  logic       hex_ready,
    output logic       pat_err,
    output logic       ovf,
    output logic [7:0] err_count
);

    localparam int unsigned SEG_W = 7;
    localparam int unsigned HEX_W = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned ERR_W = 8;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] ACC_LVL = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [SEG_W-1:0]   sample_q, sample_d;
    logic [SEG_W-1:0]   prev_q, prev_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [HEX_W-1:0]   hex_q, hex_d;
    logic               pat_err_q, pat_err_d;
    logic               ovf_q, ovf_d;
    logic [ERR_W-1:0]   err_q, err_d;

    logic [SEG_W-1:0]   seg_norm_c;
    logic               changed_c;
    logic               accept_c;
    logic [HEX_W-1:0]   code_c;
    logic               legal_c;
    logic               blank_c;
    logic               load_c;
    logic               handshake_c;

    // Bring the raw pins to active-high {a..g} before anything else sees them.
    always_comb begin
        seg_norm_c = seg_in;
        if (Common_Anode_Cathode == 0) begin
            seg_norm_c = ~seg_in;
        end
    end

    // Sample pipeline and stability counter.
    always_comb begin
        sample_d  = seg_norm_c;
        prev_d    = sample_q;
        changed_c = (sample_q != prev_q);
        cnt_d     = cnt_q;
        if (changed_c) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_MAX) begin
            cnt_d = CNT_MAX;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // With STABLE_CYCLES=1 the accept level is 0, reached on the change edge itself.
        accept_c = (cnt_d == ACC_LVL) && (changed_c || (cnt_q != ACC_LVL));
    end

    // Pattern decode of the registered sample.
    always_comb begin
        code_c  = '0;
        legal_c = 1'b1;
        blank_c = 1'b0;
        case (sample_q)
            7'b1111110: code_c = 4'h0;
            7'b0110000: code_c = 4'h1;
            7'b1101101: code_c = 4'h2;
            7'b1111001: code_c = 4'h3;
            7'b0110011: code_c = 4'h4;
            7'b1011011: code_c = 4'h5;
            7'b1011111: code_c = 4'h6;
            7'b1110000: code_c = 4'h7;
            7'b1111111: code_c = 4'h8;
            7'b1111011: code_c = 4'h9;
            7'b1110111: code_c = 4'hA;
            7'b0011111: code_c = 4'hB;
            7'b1001110: code_c = 4'hC;
            7'b0111101: code_c = 4'hD;
            7'b1001111: code_c = 4'hE;
            7'b1000111: code_c = 4'hF;
            7'b0000000: blank_c = 1'b1;
            default:    legal_c = 1'b0;
        endcase
    end

    // Output FSM, overflow and error reporting.
    always_comb begin
        state_d     = state_q;
        hex_d       = hex_q;
        pat_err_d   = 1'b0;
        ovf_d       = 1'b0;
        err_d       = err_q;
        load_c      = accept_c && legal_c && !blank_c;
        handshake_c = (state_q == ST_HOLD) && hex_ready;

        case (state_q)
            ST_IDLE: begin
                if (load_c) begin
                    hex_d   = code_c;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (handshake_c) begin
                    if (load_c) begin
                        hex_d = code_c;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (load_c) begin
                    ovf_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept_c && !legal_c) begin
            pat_err_d = 1'b1;
            if (err_q != ERR_MAX) begin
                err_d = err_q + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sample_q  <= '0;
            prev_q    <= '0;
            cnt_q     <= '0;
            hex_q     <= '0;
            pat_err_q <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            sample_q  <= sample_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            hex_q     <= hex_d;
            pat_err_q <= pat_err_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
        end
    end

    assign hex_out   = hex_q;
    assign hex_valid = (state_q == ST_HOLD);
    assign pat_err   = pat_err_q;
    assign ovf       = ovf_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_seg7_to_hex.sv
// Directed bench for seg7_to_hex: one active-high instance and one active-low instance.
module tb_seg7_to_hex;

    logic       clk;
    logic       rst;
    logic       hex_ready;
    logic [6:0] seg_a, seg_b;
    logic [3:0] hex_a, hex_b;
    logic       valid_a, valid_b;
    logic       perr_a, perr_b;
    logic       ovf_a, ovf_b;
    logic [7:0] errc_a, errc_b;

    int checks   = 0;
    int failures = 0;

    seg7_to_hex #(.Common_Anode_Cathode(1), .STABLE_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .seg_in(seg_a), .hex_out(hex_a), .hex_valid(valid_a),
        .hex_ready(hex_ready), .pat_err(perr_a), .ovf(ovf_a), .err_count(errc_a)
    );

    seg7_to_hex #(.Common_Anode_Cathode(0), .STABLE_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst), .seg_in(seg_b), .hex_out(hex_b), .hex_valid(valid_b),
        .hex_ready(hex_ready), .pat_err(perr_b), .ovf(ovf_b), .err_count(errc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; hex_ready = 1'b1; seg_a = 7'b0000000; seg_b = 7'b1111111;
        tick(); tick();
        checks++; if (hex_a !== 4'h0) begin failures++; $display("FAIL reset_hex got=%h exp=0", hex_a); end
        checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
        checks++; if (perr_a !== 1'b0) begin failures++; $display("FAIL reset_pat_err got=%b exp=0", perr_a); end
        checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf_a); end
        checks++; if (errc_a !== 8'd0) begin failures++; $display("FAIL reset_err_count got=%0d exp=0", errc_a); end
        checks++; if (valid_b !== 1'b0) begin failures++; $display("FAIL reset_valid_b got=%b exp=0", valid_b); end
        rst = 1'b0;
    endtask

    task automatic test_latency();
        seg_a = 7'b1111001;
        for (int e = 1; e <= 6; e++) begin
            logic exp_v;
            tick();
            exp_v = (e == 5);
            checks++;
            if (valid_a !== exp_v) begin failures++; $display("FAIL latency_valid edge=%0d got=%b exp=%b", e, valid_a, exp_v); end
            if (e == 5) begin
                checks++;
                if (hex_a !== 4'h3) begin failures++; $display("FAIL latency_hex got=%h exp=3", hex_a); end
            end
        end
    endtask

    task automatic test_active_low();
        seg_b = 7'b0001000;
        for (int e = 1; e <= 6; e++) begin
            logic exp_v;
            tick();
            exp_v = (e == 5);
            checks++;
            if (valid_b !== exp_v) begin failures++; $display("FAIL active_low_valid edge=%0d got=%b exp=%b", e, valid_b, exp_v); end
            if (e == 5) begin
                checks++;
                if (hex_b !== 4'hA) begin failures++; $display("FAIL active_low_hex got=%h exp=a", hex_b); end
            end
        end
        seg_b = 7'b1111111;
    endtask

    task automatic test_change();
        seg_a = 7'b0110000;
        for (int e = 1; e <= 3; e++) begin
            tick();
            checks++;
            if (valid_a !== 1'b0) begin failures++; $display("FAIL change_short_valid edge=%0d got=%b exp=0", e, valid_a); end
        end
        seg_a = 7'b1101101;
        for (int e = 1; e <= 6; e++) begin
            logic exp_v;
            tick();
            exp_v = (e == 5);
            checks++;
            if (valid_a !== exp_v) begin failures++; $display("FAIL change_valid edge=%0d got=%b exp=%b", e, valid_a, exp_v); end
            if (e == 5) begin
                checks++;
                if (hex_a !== 4'h2) begin failures++; $display("FAIL change_hex got=%h exp=2", hex_a); end
            end
        end
    endtask

    task automatic test_blank();
        seg_a = 7'b0000000;
        for (int e = 1; e <= 7; e++) begin
            tick();
            checks++;
            if (valid_a !== 1'b0 || perr_a !== 1'b0) begin
                failures++; $display("FAIL blank edge=%0d valid=%b pat_err=%b exp=0/0", e, valid_a, perr_a);
            end
        end
    endtask

    task automatic test_illegal();
        int pulses;
        pulses = 0;
        seg_a = 7'b1010101;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (perr_a === 1'b1) pulses++;
            checks++;
            if (valid_a !== 1'b0) begin failures++; $display("FAIL illegal_valid edge=%0d got=%b exp=0", e, valid_a); end
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL illegal_pulses got=%0d exp=1", pulses); end
        checks++; if (errc_a !== 8'd1) begin failures++; $display("FAIL illegal_err_count got=%0d exp=1", errc_a); end
        for (int ep = 1; ep <= 254; ep++) begin
            seg_a = (ep % 2 == 1) ? 7'b0101010 : 7'b1010101;
            for (int e = 1; e <= 5; e++) tick();
        end
        checks++; if (errc_a !== 8'd255) begin failures++; $display("FAIL err_count_255 got=%0d exp=255", errc_a); end
        pulses = 0;
        seg_a = 7'b0101010;
        for (int e = 1; e <= 5; e++) begin
            tick();
            if (perr_a === 1'b1) pulses++;
        end
        checks++; if (errc_a !== 8'd255) begin failures++; $display("FAIL err_count_sat got=%0d exp=255", errc_a); end
        checks++; if (pulses != 1) begin failures++; $display("FAIL sat_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_ovf();
        int pulses;
        pulses = 0;
        hex_ready = 1'b0;
        seg_a = 7'b1011011;
        for (int e = 1; e <= 5; e++) tick();
        checks++;
        if (valid_a !== 1'b1 || hex_a !== 4'h5) begin failures++; $display("FAIL ovf_first valid=%b hex=%h exp=1/5", valid_a, hex_a); end
        seg_a = 7'b1110000;
        for (int e = 1; e <= 6; e++) begin
            logic exp_o;
            tick();
            exp_o = (e == 5);
            if (ovf_a === 1'b1) pulses++;
            checks++;
            if (ovf_a !== exp_o) begin failures++; $display("FAIL ovf_pulse edge=%0d got=%b exp=%b", e, ovf_a, exp_o); end
            checks++;
            if (valid_a !== 1'b1 || hex_a !== 4'h5) begin failures++; $display("FAIL ovf_hold edge=%0d valid=%b hex=%h exp=1/5", e, valid_a, hex_a); end
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL ovf_pulses got=%0d exp=1", pulses); end
        hex_ready = 1'b1;
        tick();
        checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL ovf_release got=%b exp=0", valid_a); end
    endtask

    task automatic test_back_to_back();
        hex_ready = 1'b0;
        seg_a = 7'b1001110;
        for (int e = 1; e <= 5; e++) tick();
        checks++;
        if (valid_a !== 1'b1 || hex_a !== 4'hC) begin failures++; $display("FAIL b2b_first valid=%b hex=%h exp=1/c", valid_a, hex_a); end
        seg_a = 7'b0111101;
        for (int e = 1; e <= 4; e++) tick();
        checks++;
        if (hex_a !== 4'hC) begin failures++; $display("FAIL b2b_keep got=%h exp=c", hex_a); end
        hex_ready = 1'b1;
        tick();
        checks++;
        if (valid_a !== 1'b1 || hex_a !== 4'hD) begin failures++; $display("FAIL b2b_load valid=%b hex=%h exp=1/d", valid_a, hex_a); end
        checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL b2b_ovf got=%b exp=0", ovf_a); end
        tick();
        checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", valid_a); end
    endtask

    task automatic test_reset_hold();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int ep = 0; ep < 3; ep++) begin
            seg_a = (ep % 2 == 0) ? 7'b1010101 : 7'b0101010;
            for (int e = 1; e <= 5; e++) tick();
        end
        checks++; if (errc_a !== 8'd3) begin failures++; $display("FAIL rh_err3 got=%0d exp=3", errc_a); end
        hex_ready = 1'b0;
        seg_a = 7'b1001111;
        for (int e = 1; e <= 5; e++) tick();
        checks++;
        if (valid_a !== 1'b1 || hex_a !== 4'hE) begin failures++; $display("FAIL rh_hold valid=%b hex=%h exp=1/e", valid_a, hex_a); end
        rst = 1'b1;
        tick();
        checks++;
        if (hex_a !== 4'h0 || valid_a !== 1'b0 || perr_a !== 1'b0 || ovf_a !== 1'b0 || errc_a !== 8'd0) begin
            failures++;
            $display("FAIL rh_clear hex=%h valid=%b pat_err=%b ovf=%b err=%0d exp=all 0", hex_a, valid_a, perr_a, ovf_a, errc_a);
        end
        rst = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            logic exp_v;
            tick();
            exp_v = (e == 5);
            checks++;
            if (valid_a !== exp_v) begin failures++; $display("FAIL rh_relatch edge=%0d got=%b exp=%b", e, valid_a, exp_v); end
            if (e == 5) begin
                checks++;
                if (hex_a !== 4'hE) begin failures++; $display("FAIL rh_hex got=%h exp=e", hex_a); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_active_low();
        test_change();
        test_blank();
        test_illegal();
        test_ovf();
        test_back_to_back();
        test_reset_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_to_hex.md
SEG7_TO_HEX -- requirements
Module: seg7_to_hex

Interface
REQ-001 The block SHALL have parameter Common_Anode_Cathode, default 0: 1 = seg_in active-high, passed through; 0 = seg_in active-low, inverted internally before all other processing.
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 4, legal range 1..255: number of consecutive identical samples required before a pattern is accepted.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port seg_in, input, 7 bits: segment pattern, bit6 = a, bit5 = b, bit4 = c, bit3 = d, bit2 = e, bit1 = f, bit0 = g.
REQ-006 The block SHALL have port hex_out, output, 4 bits: decoded nibble, valid while hex_valid = 1.
REQ-007 The block SHALL have port hex_valid, output, 1 bit: decoded nibble available.
REQ-008 The block SHALL have port hex_ready, input, 1 bit: consumer accepts hex_out when hex_valid = 1 and hex_ready = 1 on the same edge.
REQ-009 The block SHALL have port pat_err, output, 1 bit: one-cycle pulse when an accepted pattern is illegal.
REQ-010 The block SHALL have port ovf, output, 1 bit: one-cycle pulse when a legal accepted code is dropped.
REQ-011 The block SHALL have port err_count, output, 8 bits: saturating count of pat_err pulses.

Function
REQ-012 Normalized patterns (active-high, {a..g}) SHALL decode as: 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9, 1110111=A, 0011111=B, 1001110=C, 0111101=D, 1001111=E, 1000111=F.
REQ-013 Normalized 0000000 (blank) SHALL be legal, SHALL produce no output, and SHALL NOT raise pat_err.
REQ-014 Every pattern not listed in REQ-012/REQ-013 SHALL be illegal.
REQ-015 seg_in SHALL be registered every edge; a stability counter SHALL clear to 0 when the registered sample differs from the previous sample, and SHALL otherwise increment, saturating at STABLE_CYCLES.
REQ-016 An accept event SHALL occur exactly once per stable episode, on the edge the counter first reaches STABLE_CYCLES-1 with an unchanged sample; a new episode SHALL require a pattern change.
REQ-017 Latency: hex_valid SHALL rise on the (STABLE_CYCLES+1)th rising edge on which seg_in has carried the new constant value.
REQ-018 Output FSM SHALL have states IDLE (hex_valid = 0) and HOLD (hex_valid = 1).
REQ-019 IDLE + accept of a legal non-blank pattern SHALL load hex_out and go to HOLD.
REQ-020 HOLD SHALL keep hex_out and hex_valid constant until handshake; on handshake without accept, the FSM SHALL go to IDLE.
REQ-021 HOLD + handshake + legal non-blank accept on the same edge SHALL load the new code and stay in HOLD, with no ovf.
REQ-022 HOLD + legal non-blank accept without handshake SHALL drop the new code, retain the old code, and pulse ovf for one cycle.
REQ-023 An illegal accept SHALL pulse pat_err for one cycle in any state and SHALL increment err_count, saturating at 255, without changing the FSM state.
REQ-024 A blank accept SHALL affect nothing.

Reset
REQ-025 While rst = 1 at an edge, hex_out SHALL be 0, hex_valid 0, pat_err 0, ovf 0, err_count 0, FSM IDLE, stability counter 0, and sample registers 0.
REQ-026 Reset asserted in HOLD SHALL discard the pending code.
REQ-027 After release, the first accept SHALL require a full STABLE_CYCLES+1 edges of constant input.

Verification
REQ-028 Common_Anode_Cathode=1, STABLE_CYCLES=4, hex_ready=1, seg_in=1111001 held -> hex_valid=1 with hex_out=3 on the 5th edge, for one cycle only.
REQ-029 Common_Anode_Cathode=0, seg_in=0001000 held -> hex_out=A, hex_valid=1.
REQ-030 seg_in=0110000 for 3 edges, then 1101101 held -> no output for 1, then hex_out=2 on the 5th edge after the change.
REQ-031 seg_in=1010101 held 10 edges -> exactly one pat_err pulse, err_count=1, hex_valid stays 0; 256 such episodes -> err_count=255.
REQ-032 hex_ready=0, code 5 accepted, then code 7 accepted -> ovf pulse once, hex_out stays 5; raise hex_ready -> hex_valid falls next edge.
REQ-033 rst=1 for one edge while in HOLD with err_count=3 -> all outputs 0 on that edge; re-held pattern yields output STABLE_CYCLES+1 edges after release.
